calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DIGITS, 4, maximum BCD digits accepted per operand (1..4) SHALL be supported.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 key_valid  in  1  one-cycle pulse, key_code valid.
REQ-005 key_code  in  4  codes: 0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD equals, 0xE clear, 0xF no-op.
REQ-006 operand_a  out  16  BCD operand A, four digits.
REQ-007 operand_b  out  16  BCD operand B, four digits.
REQ-008 alu_op  out  2  00 add, 01 sub, 10 mul.
REQ-009 alu_start  out  1  one-cycle compute request.
REQ-010 alu_done  in  1  one-cycle completion pulse.
REQ-011 alu_result  in  16  BCD result, sampled with alu_done.
REQ-012 alu_error  in  1  overflow/invalid flag, sampled with alu_done.
REQ-013 disp_value  out  16  BCD value for the display driver.
REQ-014 digit_en  out  4  active-low digit enables, bit0 = rightmost digit.
REQ-015 err  out  1  high while in ERROR.
REQ-016 state_o  out  3  current state, for debug.

Function
REQ-017 The states SHALL be IDLE=000, ENTER_A=001, ENTER_B=010, WAIT_ALU=011, SHOW=100, ERROR=101; codes 110/111 SHALL go to IDLE on the next edge.
REQ-018 A key SHALL be accepted on the rising edge where key_valid=1; all outputs are registered and SHALL show the effect after that edge.
REQ-019 Digit entry SHALL shift the target operand left 4 bits, insert the digit at [3:0], and increment the digit count; it SHALL be ignored once the count equals DIGITS.
REQ-020 IDLE transitions: digit -> ENTER_A with A=digit and count=1; operator -> ENTER_B with A=0 and op latched; equals and 0xF ignored.
REQ-021 ENTER_A transitions: digit -> entry; operator -> latch op, clear B and count, go to ENTER_B; equals ignored.
REQ-022 ENTER_B transitions: digit -> entry; operator -> replace op and stay; equals -> WAIT_ALU with alu_start=1 for exactly that one cycle (B=0 if no digits entered).
REQ-023 WAIT_ALU SHALL ignore all keys except clear; on alu_done it SHALL latch alu_result and go to ERROR if alu_error=1, otherwise to SHOW.
REQ-024 alu_done SHALL be honoured in the same cycle alu_start is high (zero-latency ALU).
REQ-025 alu_done outside WAIT_ALU SHALL be ignored.
REQ-026 SHOW transitions: digit -> ENTER_A with A=digit, B=0, count=1; equals ignored; operator per REQ-038.
REQ-027 ERROR SHALL ignore every key except clear.
REQ-028 Clear SHALL go to IDLE from any state and zero operands, result, count and op.
REQ-029 If clear and alu_done occur in the same cycle, clear SHALL win and the result SHALL be discarded.
REQ-030 operand_a, operand_b and alu_op SHALL stay constant from alu_start until leaving WAIT_ALU.
REQ-031 disp_value SHALL be:
  - IDLE: 0
  - ENTER_A: operand_a
  - ENTER_B and WAIT_ALU: operand_b
  - SHOW: latched result
  - ERROR: 0xEEEE
REQ-032 digit_en SHALL enable the lowest max(count,1) digits in IDLE and entry states (IDLE = 4'b1110), all digits (4'b0000) in SHOW and ERROR, and hold its ENTER_B value in WAIT_ALU.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, without waiting for a clock edge.
REQ-034 Reset values: operand_a=0, operand_b=0, alu_op=00, alu_start=0, disp_value=0, digit_en=4'b1110, err=0, state_o=000.
REQ-035 Reset mid-operation, including in WAIT_ALU, SHALL abandon the calculation; a later alu_done SHALL be ignored.
REQ-036 Release of reset SHALL take effect at the next rising clk edge.

Configuration
REQ-037 Macro CALC_CHAIN_EN SHALL control result chaining.
REQ-038 With CALC_CHAIN_EN defined, an operator in SHOW SHALL load A=result, latch op, clear B, and go to ENTER_B.
REQ-039 Without CALC_CHAIN_EN, an operator in SHOW SHALL be ignored and the block SHALL stay in SHOW.

Verification
REQ-040 Keys 1,2,+,3,=; ALU returns 0x0015 two cycles later -> single alu_start, operand_a=0x0012, operand_b=0x0003, alu_op=00; SHOW, disp_value=0x0015, digit_en=0000.
REQ-041 Keys 1,2,3,4,5 from IDLE -> operand_a=0x1234, fifth digit ignored, digit_en=0000.
REQ-042 ALU done with alu_error=1 -> ERROR, err=1, disp_value=0xEEEE; digit 7 ignored; clear -> IDLE, all outputs at reset values.
REQ-043 Clear coincident with alu_done in WAIT_ALU -> IDLE, err=0, disp_value=0.
REQ-044 From SHOW 0x0015, keys -,5,= -> with CALC_CHAIN_EN operand_a=0x0015, operand_b=0x0005, alu_op=01; without it the operator is ignored, state_o=100, and the digit 5 starts a new A=0x0005.
REQ-045 reset pulsed low mid-cycle during ENTER_B -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU and display signals of the calculator sequencer.
interface calc_sequencer_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [1:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        alu_error;
   logic [15:0] disp_value;
   logic [3:0]  digit_en;
   logic        err;
   logic [2:0]  state_o;
   modport slave (
      input  key_valid, key_code, alu_done, alu_result, alu_error,
      output operand_a, operand_b, alu_op, alu_start, disp_value, digit_en, err, state_o
   );
   modport master (
      output key_valid, key_code, alu_done, alu_result, alu_error,
      input  operand_a, operand_b, alu_op, alu_start, disp_value, digit_en, err, state_o
   );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator sequencer feeding a BCD ALU and a display.
// Define CALC_CHAIN_EN to let an operator in SHOW chain the result into operand A.
module calc_sequencer #(
   parameter int DIGITS = 4
) (
   input logic             clk,
   input logic             reset,
   calc_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE = 3'b000, ENTER_A = 3'b001, ENTER_B = 3'b010,
      WAIT_ALU = 3'b011, SHOW = 3'b100, ERROR = 3'b101
   } state_t;
   localparam logic [2:0] MAX_CNT = 3'(DIGITS);
   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d, key_op;
   logic        start_q, start_d;
   logic [3:0]  k, mask;
   logic        is_dig, is_op, is_eq, is_clr, full;
   assign k      = bus.key_code;
   assign is_dig = bus.key_valid && k <= 4'd9;
   assign is_op  = bus.key_valid && k >= 4'hA && k <= 4'hC;
   assign is_eq  = bus.key_valid && k == 4'hD;
   assign is_clr = bus.key_valid && k == 4'hE;
   assign full   = cnt_q == MAX_CNT;
   // A/B/C map onto 00/01/10 by adding 2 modulo 4
   assign key_op = k[1:0] + 2'd2;
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      start_d = 1'b0;
      if (is_clr) begin
         state_d = IDLE;
         a_d     = '0;
         b_d     = '0;
         res_d   = '0;
         cnt_d   = '0;
         op_d    = '0;
      end else begin
         case (state_q)
            IDLE, SHOW: begin
               if (is_dig) begin
                  state_d = ENTER_A;
                  a_d     = {12'd0, k};
                  b_d     = '0;
                  cnt_d   = 3'd1;
               end else if (is_op && state_q == IDLE) begin
                  state_d = ENTER_B;
                  a_d     = '0;
                  b_d     = '0;
                  cnt_d   = '0;
                  op_d    = key_op;
               end
`ifdef CALC_CHAIN_EN
               else if (is_op) begin
                  state_d = ENTER_B;
                  a_d     = res_q;
                  b_d     = '0;
                  cnt_d   = '0;
                  op_d    = key_op;
               end
`endif
            end
            ENTER_A: begin
               if (is_dig && !full) begin
                  a_d   = {a_q[11:0], k};
                  cnt_d = cnt_q + 3'd1;
               end else if (is_op) begin
                  state_d = ENTER_B;
                  b_d     = '0;
                  cnt_d   = '0;
                  op_d    = key_op;
               end
            end
            ENTER_B: begin
               if (is_dig && !full) begin
                  b_d   = {b_q[11:0], k};
                  cnt_d = cnt_q + 3'd1;
               end else if (is_op) begin
                  op_d = key_op;
               end else if (is_eq) begin
                  state_d = WAIT_ALU;
                  start_d = 1'b1;
               end
            end
            WAIT_ALU: begin
               if (bus.alu_done) begin
                  res_d   = bus.alu_result;
                  state_d = bus.alu_error ? ERROR : SHOW;
               end
            end
            ERROR: ;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         start_q <= start_d;
      end
   end
   assign mask = cnt_q <= 3'd1 ? 4'b0001 : cnt_q == 3'd2 ? 4'b0011 : cnt_q == 3'd3 ? 4'b0111 : 4'b1111;
   assign bus.operand_a  = a_q;
   assign bus.operand_b  = b_q;
   assign bus.alu_op     = op_q;
   assign bus.alu_start  = start_q;
   assign bus.err        = state_q == ERROR;
   assign bus.state_o    = state_q;
   assign bus.digit_en   = (state_q == SHOW || state_q == ERROR) ? 4'b0000 : ~mask;
   assign bus.disp_value = state_q == ENTER_A ? a_q :
                           (state_q == ENTER_B || state_q == WAIT_ALU) ? b_q :
                           state_q == SHOW ? res_q :
                           state_q == ERROR ? 16'hEEEE : 16'h0000;
endmodule
